// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the FSM state encoding and synchronizer depth.
package rst_seq_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    WAIT_ACK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/rst_sync.sv
// Reset release synchronizer: async assert, clocked release.
// Output rises SYNC_STAGES edges after rst_n deasserts.
module rst_sync
  import rst_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift a constant one through the chain once reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Multi-domain reset sequencer: hold, release one domain
// at a time on ack, with timeout and soft restart.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 16,
  parameter int TMO_CYC  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_req,
  input  logic [N_DOM-1:0]         dom_ack,
  output logic [N_DOM-1:0]         dom_rst_n,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(N_DOM)-1:0] err_dom
);

  localparam int IW = $clog2(N_DOM);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [IW-1:0] LAST  = IW'(N_DOM - 1);
  localparam logic [HW-1:0] H_END = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] H_SAT = HW'(HOLD_CYC);
  localparam logic [TW-1:0] T_END = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] T_SAT = TW'(TMO_CYC);

  logic            rst_n_sync;
  state_t          state_q;
  state_t          state;
  state_t          state_d;
  logic [HW-1:0]   hcnt_q;
  logic [HW-1:0]   hcnt_d;
  logic [TW-1:0]   tcnt_q;
  logic [TW-1:0]   tcnt_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [IW-1:0]   err_dom_d;
  logic [N_DOM-1:0] rel_d;

  rst_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

  // state_q is pre-loaded with HOLD while the synchronizer fills,
  // so HOLD becomes visible on the same edge the release lands.
  assign state = rst_n_sync ? state_q : SYNC;

  // Next-state, counters and timed-out index; soft_req wins over all
  always_comb begin
    state_d   = state;
    hcnt_d    = hcnt_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    err_dom_d = err_dom;
    if (state != SYNC && soft_req) begin
      state_d   = HOLD;
      hcnt_d    = '0;
      tcnt_d    = '0;
      idx_d     = '0;
      err_dom_d = '0;
    end else begin
      unique case (state)
        SYNC: begin
          state_d   = HOLD;
          hcnt_d    = '0;
          tcnt_d    = '0;
          idx_d     = '0;
          err_dom_d = '0;
        end
        HOLD: begin
          if (hcnt_q == H_END) begin
            state_d = WAIT_ACK;
            idx_d   = '0;
            tcnt_d  = '0;
          end else if (hcnt_q != H_SAT) begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        WAIT_ACK: begin
          if (dom_ack[idx_q]) begin
            tcnt_d = '0;
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else if (tcnt_q == T_END) begin
            state_d   = ERR;
            err_dom_d = idx_q;
          end else if (tcnt_q != T_SAT) begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  // Domain reset mask for the upcoming state: released up to idx
  always_comb begin
    rel_d = '0;
    unique case (state_d)
      WAIT_ACK: begin
        for (int j = 0; j < N_DOM; j++) begin
          rel_d[j] = (IW'(j) <= idx_d);
        end
      end
      DONE: begin
        rel_d = '1;
      end
      default: begin
        rel_d = '0;
      end
    endcase
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      hcnt_q    <= '0;
      tcnt_q    <= '0;
      idx_q     <= '0;
      dom_rst_n <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_dom   <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      tcnt_q    <= tcnt_d;
      idx_q     <= idx_d;
      dom_rst_n <= rel_d;
      done      <= (state_d == DONE);
      err       <= (state_d == ERR);
      err_dom   <= err_dom_d;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Randomized bench for rst_seq against an event-time model.
// Expected outputs come from planned release/done/error cycles.
module tb_rst_seq;

  localparam int ND    = 4;
  localparam int HC    = 16;
  localparam int TC    = 64;
  localparam int NEVER = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_req = 1'b0;
  logic [3:0] dom_ack = 4'b0;
  logic [3:0] dom_rst_n;
  logic       done;
  logic       err;
  logic [1:0] err_dom;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;
  int dly [ND];
  int rel [ND];
  int done_t;
  int err_t;
  int err_i;

  rst_seq #(
    .N_DOM    (ND),
    .HOLD_CYC (HC),
    .TMO_CYC  (TC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_req  (soft_req),
    .dom_ack   (dom_ack),
    .dom_rst_n (dom_rst_n),
    .done      (done),
    .err       (err),
    .err_dom   (err_dom)
  );

  always #5 clk = ~clk;

  // b = cycle index at which HOLD starts; dly<0 means ack held high early
  function automatic void plan(int b);
    int w;
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < ND; i++) rel[i] = NEVER;
    done_t = NEVER;
    err_t  = NEVER;
    err_i  = 0;
    rel[0] = b + HC;
    for (int i = 0; i < ND; i++) begin
      if (!stop) begin
        w = (dly[i] < 0) ? 0 : dly[i];
        if (w >= TC) begin
          err_t = rel[i] + TC;
          err_i = i;
          stop  = 1'b1;
        end else if (i < ND - 1) begin
          rel[i+1] = rel[i] + w + 1;
        end else begin
          done_t = rel[i] + w + 1;
        end
      end
    end
  endfunction

  function automatic int end_t();
    return ((done_t < err_t) ? done_t : err_t) + 4;
  endfunction

  // {dom_rst_n, done, err, err_dom} expected after edge kk
  function automatic logic [7:0] expv(int kk);
    logic [3:0] d;
    d = 4'b0;
    if (kk >= err_t) return {4'b0, 1'b0, 1'b1, 2'(err_i)};
    for (int i = 0; i < ND; i++) d[i] = (kk >= rel[i]);
    return {d, (kk >= done_t), 1'b0, 2'b00};
  endfunction

  function automatic logic [7:0] obs(logic [7:0] e);
    return {dom_rst_n, done, err, e[2] ? err_dom : 2'b00};
  endfunction

  // Ack held low after release until its planned cycle, noise elsewhere
  function automatic logic [3:0] ack_at(int kk);
    logic [3:0] a;
    int w;
    for (int i = 0; i < ND; i++) begin
      w = (dly[i] < 0) ? 0 : dly[i];
      if (kk < rel[i]) a[i] = (dly[i] < 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (kk < rel[i] + w) a[i] = 1'b0;
      else if (kk == rel[i] + w) a[i] = 1'b1;
      else a[i] = 1'($urandom_range(0, 1));
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
    soft_req = 1'b0;
    dom_ack  = ack_at(k);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    dom_ack = ack_at(0);
  endtask

  task automatic restart_rst();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    plan(2);
    release_rst();
  endtask

  task automatic rand_dly(int hi);
    for (int i = 0; i < ND; i++) dly[i] = $urandom_range(0, hi + 1) - 1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      dom_ack  = 4'($urandom_range(0, 15));
      soft_req = 1'($urandom_range(0, 1));
      o = {dom_rst_n, done, err, err_dom};
      n_vec++;
      if (o !== 8'h00) begin
        n_bad++;
        $display("FAIL reset got %b want %b", o, 8'h00);
      end
    end
    soft_req = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] e;
    dly = '{3, 3, 3, 3};
    plan(2);
    release_rst();
    soft_req = 1'b1;
    while (k < end_t()) begin
      tick();
      if (k == 1) soft_req = 1'b1;
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL nominal k=%0d got %b want %b", k, obs(e), e);
      end
    end
  endtask

  task automatic test_early();
    logic [7:0] e;
    dly = '{-1, -1, -1, -1};
    restart_rst();
    while (k < end_t()) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL early k=%0d got %b want %b", k, obs(e), e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    int ph;
    dly = '{3, TC - 1, 1000, 0};
    restart_rst();
    ph = 0;
    while (k < end_t()) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL timeout p%0d k=%0d got %b want %b", ph, k, obs(e), e);
      end
      if (ph == 0 && k == err_t + 3) begin
        soft_req = 1'b1;
        dly = '{0, 2, 5, TC};
        plan(k + 1);
        ph = 1;
      end else if (ph == 1 && k == err_t + 2) begin
        soft_req = 1'b1;
        dly = '{1, 1, 1, TC + 5};
        plan(k + 1);
        ph = 2;
      end else if (ph == 2 && k == err_t - 1) begin
        soft_req = 1'b1;
        dly = '{2, 2, 2, 2};
        plan(k + 1);
        ph = 3;
      end
    end
  endtask

  task automatic test_soft();
    logic [7:0] e;
    int ph;
    dly = '{1, 4, 0, 2};
    restart_rst();
    ph = 0;
    while (k < end_t()) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL soft p%0d k=%0d got %b want %b", ph, k, obs(e), e);
      end
      if (ph == 0 && k == done_t + 2) begin
        soft_req = 1'b1;
        dly = '{1, 4, 0, 2};
        plan(k + 1);
        ph = 1;
      end else if (ph == 1 && k == rel[0] - 6) begin
        soft_req = 1'b1;
        rand_dly(6);
        plan(k + 1);
        ph = 2;
      end else if (ph == 2 && k == rel[1] + 1) begin
        soft_req = 1'b1;
        rand_dly(6);
        plan(k + 1);
        ph = 3;
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] e;
    bit hit;
    dly = '{1, 2, 3, 4};
    restart_rst();
    hit = 1'b0;
    while (k < end_t()) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL collision k=%0d got %b want %b", k, obs(e), e);
      end
      if (!hit && k == rel[3] + 4) begin
        soft_req = 1'b1;
        dly = '{0, 1, 0, 1};
        plan(k + 1);
        hit = 1'b1;
      end
    end
  endtask

  task automatic test_midreset();
    logic [7:0] e;
    logic [7:0] o;
    dly = '{2, 6, 2, 2};
    restart_rst();
    while (k < rel[1] + 2) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL midrst k=%0d got %b want %b", k, obs(e), e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = {dom_rst_n, done, err, err_dom};
    n_vec++;
    if (o !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_async got %b want %b", o, 8'h00);
    end
    rand_dly(5);
    restart_rst();
    while (k < end_t()) begin
      tick();
      e = expv(k);
      n_vec++;
      if (obs(e) !== e) begin
        n_bad++;
        $display("FAIL midrst_rerun k=%0d got %b want %b", k, obs(e), e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    int sk;
    bit used;
    for (int it = 0; it < 8; it++) begin
      rand_dly(7);
      if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, ND - 1)] = TC + 6;
      restart_rst();
      sk = $urandom_range(0, 1) ? $urandom_range(3, 60) : NEVER;
      used = 1'b0;
      while (k < end_t()) begin
        tick();
        e = expv(k);
        n_vec++;
        if (obs(e) !== e) begin
          n_bad++;
          $display("FAIL random it=%0d k=%0d got %b want %b", it, k, obs(e), e);
        end
        if (!used && k == sk) begin
          soft_req = 1'b1;
          rand_dly(7);
          plan(k + 1);
          used = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_early();
    test_timeout();
    test_soft();
    test_collision();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
